// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: decode-stage fields in (*_id) and EX-stage fields out (*_ex).
// master = ID-side producer / EX-side consumer; slave = the pipeline register itself.
interface id_ex_stage_reg_if #(
    parameter int DW = 64
);
    // Decode-stage side
    logic          valid_id;
    logic          ALUSrc_id;
    logic          MemtoReg_id;
    logic          RegWrite_id;
    logic          MemRead_id;
    logic          MemWrite_id;
    logic          Branch_id;
    logic [1:0]    ALUOp_id;
    logic [10:0]   Opcode_id;
    logic [DW-1:0] PC_id;
    logic [DW-1:0] ReadData1_id;
    logic [DW-1:0] ReadData2_id;
    logic [DW-1:0] SignExt_id;
    logic [4:0]    Rn_id;
    logic [4:0]    Rm_id;
    logic [4:0]    Rd_id;

    // Execute-stage side
    logic          valid_ex;
    logic          ALUSrc_ex;
    logic          MemtoReg_ex;
    logic          RegWrite_ex;
    logic          MemRead_ex;
    logic          MemWrite_ex;
    logic          Branch_ex;
    logic [1:0]    ALUOp_ex;
    logic [10:0]   Opcode_ex;
    logic [DW-1:0] PC_ex;
    logic [DW-1:0] ReadData1_ex;
    logic [DW-1:0] ReadData2_ex;
    logic [DW-1:0] SignExt_ex;
    logic [4:0]    Rn_ex;
    logic [4:0]    Rm_ex;
    logic [4:0]    Rd_ex;

    modport master (
        output valid_id, ALUSrc_id, MemtoReg_id, RegWrite_id, MemRead_id,
               MemWrite_id, Branch_id, ALUOp_id, Opcode_id, PC_id,
               ReadData1_id, ReadData2_id, SignExt_id, Rn_id, Rm_id, Rd_id,
        input  valid_ex, ALUSrc_ex, MemtoReg_ex, RegWrite_ex, MemRead_ex,
               MemWrite_ex, Branch_ex, ALUOp_ex, Opcode_ex, PC_ex,
               ReadData1_ex, ReadData2_ex, SignExt_ex, Rn_ex, Rm_ex, Rd_ex
    );

    modport slave (
        input  valid_id, ALUSrc_id, MemtoReg_id, RegWrite_id, MemRead_id,
               MemWrite_id, Branch_id, ALUOp_id, Opcode_id, PC_id,
               ReadData1_id, ReadData2_id, SignExt_id, Rn_id, Rm_id, Rd_id,
        output valid_ex, ALUSrc_ex, MemtoReg_ex, RegWrite_ex, MemRead_ex,
               MemWrite_ex, Branch_ex, ALUOp_ex, Opcode_ex, PC_ex,
               ReadData1_ex, ReadData2_ex, SignExt_ex, Rn_ex, Rm_ex, Rd_ex
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the five-stage LEGv8 pipeline.
// Handles flush/stall bubbles and, when LOAD_USE_STALL_EN is defined,
// detects load-use hazards and inserts a one-cycle bubble.
// Without LOAD_USE_STALL_EN, load_use is tied low and no comparator is built.
module id_ex_stage_reg #(
    parameter int DW = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    id_ex_stage_reg_if.slave      bus,
    output logic                  load_use
);

    typedef struct packed {
        logic          valid;
        logic          alu_src;
        logic          memto_reg;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          branch;
        logic [1:0]    alu_op;
        logic [10:0]   opcode;
        logic [DW-1:0] pc;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] sext;
        logic [4:0]    rn;
        logic [4:0]    rm;
        logic [4:0]    rd;
    } stage_t;

    stage_t stage_q;
    stage_t stage_d;
    stage_t id_in;
    logic   load_use_w;

    // Capture ID fields; a non-valid slot still carries data but no control.
    always_comb begin
        id_in           = '0;
        id_in.valid     = bus.valid_id;
        id_in.alu_src   = bus.ALUSrc_id   & bus.valid_id;
        id_in.memto_reg = bus.MemtoReg_id & bus.valid_id;
        id_in.reg_write = bus.RegWrite_id & bus.valid_id;
        id_in.mem_read  = bus.MemRead_id  & bus.valid_id;
        id_in.mem_write = bus.MemWrite_id & bus.valid_id;
        id_in.branch    = bus.Branch_id   & bus.valid_id;
        id_in.alu_op    = bus.valid_id ? bus.ALUOp_id : 2'b00;
        id_in.opcode    = bus.Opcode_id;
        id_in.pc        = bus.PC_id;
        id_in.rd1       = bus.ReadData1_id;
        id_in.rd2       = bus.ReadData2_id;
        id_in.sext      = bus.SignExt_id;
        id_in.rn        = bus.Rn_id;
        id_in.rm        = bus.Rm_id;
        id_in.rd        = bus.Rd_id;
    end

`ifdef LOAD_USE_STALL_EN
    logic use_rm;
    logic hazard;

    // Load in EX whose destination feeds a source of the instruction in ID.
    // Rm matters for R-type (ALUSrc=0), CBZ (ALUSrc=0) and STUR store data.
    always_comb begin
        use_rm = ~bus.ALUSrc_id | bus.MemWrite_id;
        hazard = stage_q.valid & stage_q.mem_read & stage_q.reg_write
               & (stage_q.rd != 5'd31) & bus.valid_id
               & ((stage_q.rd == bus.Rn_id) | (use_rm & (stage_q.rd == bus.Rm_id)));
        load_use_w = hazard & ~flush;
    end
`else
    // No hardware interlock: software keeps load-use pairs apart.
    always_comb begin
        load_use_w = 1'b0;
    end
`endif

    assign load_use = load_use_w;

    // Next-state selection: flush > stall > load-use bubble > normal load.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (stall) begin
            stage_d = stage_q;
        end else if (load_use_w) begin
            stage_d = '0;
        end else begin
            stage_d = id_in;
        end
    end

    // Pipeline register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign bus.valid_ex     = stage_q.valid;
    assign bus.ALUSrc_ex    = stage_q.alu_src;
    assign bus.MemtoReg_ex  = stage_q.memto_reg;
    assign bus.RegWrite_ex  = stage_q.reg_write;
    assign bus.MemRead_ex   = stage_q.mem_read;
    assign bus.MemWrite_ex  = stage_q.mem_write;
    assign bus.Branch_ex    = stage_q.branch;
    assign bus.ALUOp_ex     = stage_q.alu_op;
    assign bus.Opcode_ex    = stage_q.opcode;
    assign bus.PC_ex        = stage_q.pc;
    assign bus.ReadData1_ex = stage_q.rd1;
    assign bus.ReadData2_ex = stage_q.rd2;
    assign bus.SignExt_ex   = stage_q.sext;
    assign bus.Rn_ex        = stage_q.rn;
    assign bus.Rm_ex        = stage_q.rm;
    assign bus.Rd_ex        = stage_q.rd;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed testbench for id_ex_stage_reg (works with or without LOAD_USE_STALL_EN).
module tb_id_ex_stage_reg;

    logic clk;
    logic reset;
    logic stall;
    logic flush;
    logic load_use;
    int   checks;
    int   errors;

`ifdef LOAD_USE_STALL_EN
    localparam logic LU = 1'b1;
`else
    localparam logic LU = 1'b0;
`endif

    id_ex_stage_reg_if #(.DW(64)) bus ();

    id_ex_stage_reg #(.DW(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .flush    (flush),
        .bus      (bus),
        .load_use (load_use)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        bus.valid_id     = 1'b0;
        bus.ALUSrc_id    = 1'b0;
        bus.MemtoReg_id  = 1'b0;
        bus.RegWrite_id  = 1'b0;
        bus.MemRead_id   = 1'b0;
        bus.MemWrite_id  = 1'b0;
        bus.Branch_id    = 1'b0;
        bus.ALUOp_id     = 2'b00;
        bus.Opcode_id    = 11'd0;
        bus.PC_id        = 64'd0;
        bus.ReadData1_id = 64'd0;
        bus.ReadData2_id = 64'd0;
        bus.SignExt_id   = 64'd0;
        bus.Rn_id        = 5'd0;
        bus.Rm_id        = 5'd0;
        bus.Rd_id        = 5'd0;
    endtask

    // ADD Xd, Xn, Xm
    task automatic set_add(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        clear_id();
        bus.valid_id     = 1'b1;
        bus.RegWrite_id  = 1'b1;
        bus.ALUOp_id     = 2'b10;
        bus.Opcode_id    = 11'h458;
        bus.PC_id        = 64'h40;
        bus.ReadData1_id = 64'd5;
        bus.ReadData2_id = 64'd7;
        bus.Rn_id        = rn;
        bus.Rm_id        = rm;
        bus.Rd_id        = rd;
    endtask

    // LDUR Xt, [Xn, #8]
    task automatic set_ldur(input logic [4:0] rt, input logic [4:0] rn);
        clear_id();
        bus.valid_id     = 1'b1;
        bus.ALUSrc_id    = 1'b1;
        bus.MemtoReg_id  = 1'b1;
        bus.RegWrite_id  = 1'b1;
        bus.MemRead_id   = 1'b1;
        bus.Opcode_id    = 11'h7C2;
        bus.PC_id        = 64'h80;
        bus.SignExt_id   = 64'd8;
        bus.Rn_id        = rn;
        bus.Rd_id        = rt;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        stall  = 1'b0;
        flush  = 1'b0;
        clear_id();
        tick();
        tick();
        check("reset_valid", 64'(bus.valid_ex), 64'd0);
        check("reset_load_use", 64'(load_use), 64'd0);
        reset = 1'b0;

        // Normal load of an ADD
        set_add(5'd3, 5'd1, 5'd2);
        tick();
        check("add_valid", 64'(bus.valid_ex), 64'd1);
        check("add_regwrite", 64'(bus.RegWrite_ex), 64'd1);
        check("add_aluop", 64'(bus.ALUOp_ex), 64'd2);
        check("add_rd", 64'(bus.Rd_ex), 64'd3);
        check("add_rd1", bus.ReadData1_ex, 64'd5);
        check("add_rd2", bus.ReadData2_ex, 64'd7);
        check("add_pc", bus.PC_ex, 64'h40);
        check("add_opcode", 64'(bus.Opcode_ex), 64'h458);
        check("add_load_use", 64'(load_use), 64'd0);

        // Asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(bus.valid_ex), 64'd0);
        check("async_rst_rd1", bus.ReadData1_ex, 64'd0);
        check("async_rst_rd", 64'(bus.Rd_ex), 64'd0);
        check("async_rst_load_use", 64'(load_use), 64'd0);
        reset = 1'b0;

        // Reload, then stall for three cycles with changed inputs
        tick();
        check("reload_rd", 64'(bus.Rd_ex), 64'd3);
        stall = 1'b1;
        set_add(5'd9, 5'd10, 5'd11);
        bus.ReadData1_id = 64'hAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_rd", 64'(bus.Rd_ex), 64'd3);
            check("stall_rd1", bus.ReadData1_ex, 64'd5);
            check("stall_valid", 64'(bus.valid_ex), 64'd1);
        end

        // Flush together with stall: flush wins
        flush = 1'b1;
        tick();
        check("flush_stall_valid", 64'(bus.valid_ex), 64'd0);
        check("flush_stall_rd1", bus.ReadData1_ex, 64'd0);
        check("flush_stall_rd", 64'(bus.Rd_ex), 64'd0);
        check("flush_stall_pc", bus.PC_ex, 64'd0);
        check("flush_stall_regwrite", 64'(bus.RegWrite_ex), 64'd0);
        flush = 1'b0;
        stall = 1'b0;
        tick();
        check("post_flush_rd", 64'(bus.Rd_ex), 64'd9);
        check("post_flush_rd1", bus.ReadData1_ex, 64'hAA);
        flush = 1'b1;
        tick();
        check("flush_only_valid", 64'(bus.valid_ex), 64'd0);
        check("flush_only_aluop", 64'(bus.ALUOp_ex), 64'd0);
        check("flush_only_rd2", bus.ReadData2_ex, 64'd0);
        flush = 1'b0;

        // valid_id=0: data copied, controls gated
        set_add(5'd3, 5'd1, 5'd2);
        bus.valid_id = 1'b0;
        bus.Branch_id = 1'b1;
        tick();
        check("inv_valid", 64'(bus.valid_ex), 64'd0);
        check("inv_regwrite", 64'(bus.RegWrite_ex), 64'd0);
        check("inv_branch", 64'(bus.Branch_ex), 64'd0);
        check("inv_aluop", 64'(bus.ALUOp_ex), 64'd0);
        check("inv_rd", 64'(bus.Rd_ex), 64'd3);
        check("inv_rd1", bus.ReadData1_ex, 64'd5);

        // Hazard negative: LDUR X31 followed by a reader of X31
        set_ldur(5'd31, 5'd5);
        tick();
        check("ldur31_memread", 64'(bus.MemRead_ex), 64'd1);
        set_add(5'd4, 5'd31, 5'd31);
        #1;
        check("xzr_load_use", 64'(load_use), 64'd0);

        // LDUR X2 in EX
        set_ldur(5'd2, 5'd5);
        #1;
        check("ldur_after_ldur_load_use", 64'(load_use), 64'd0);
        tick();
        check("ldur2_rd", 64'(bus.Rd_ex), 64'd2);
        check("ldur2_memtoreg", 64'(bus.MemtoReg_ex), 64'd1);

        // ADDI-form: Rm ignored
        set_add(5'd4, 5'd1, 5'd2);
        bus.ALUSrc_id = 1'b1;
        #1;
        check("addi_load_use", 64'(load_use), 64'd0);

        // STUR Xt=X2: store data is a real source
        set_add(5'd0, 5'd1, 5'd2);
        bus.ALUSrc_id   = 1'b1;
        bus.MemWrite_id = 1'b1;
        bus.RegWrite_id = 1'b0;
        #1;
        check("stur_load_use", 64'(load_use), 64'(LU));

        // flush suppresses the request
        flush = 1'b1;
        #1;
        check("flush_suppress_load_use", 64'(load_use), 64'd0);
        flush = 1'b0;

        // ADD X4, X2, X1 behind the load
        set_add(5'd4, 5'd2, 5'd1);
        #1;
        check("lu_add_load_use", 64'(load_use), 64'(LU));

        // stall + load_use: hold and keep requesting
        stall = 1'b1;
        tick();
        check("lu_stall_rd", 64'(bus.Rd_ex), 64'd2);
        check("lu_stall_memread", 64'(bus.MemRead_ex), 64'd1);
        check("lu_stall_load_use", 64'(load_use), 64'(LU));
        stall = 1'b0;

`ifdef LOAD_USE_STALL_EN
        tick();
        check("lu_bubble_valid", 64'(bus.valid_ex), 64'd0);
        check("lu_bubble_memread", 64'(bus.MemRead_ex), 64'd0);
        check("lu_bubble_rd", 64'(bus.Rd_ex), 64'd0);
        check("lu_after_bubble_load_use", 64'(load_use), 64'd0);
        tick();
        check("lu_add_rd", 64'(bus.Rd_ex), 64'd4);
        check("lu_add_valid", 64'(bus.valid_ex), 64'd1);
        check("lu_add_rn", 64'(bus.Rn_ex), 64'd2);
`else
        tick();
        check("nolu_add_rd", 64'(bus.Rd_ex), 64'd4);
        check("nolu_add_valid", 64'(bus.valid_ex), 64'd1);
        check("nolu_add_rn", 64'(bus.Rn_ex), 64'd2);
        check("nolu_add_aluop", 64'(bus.ALUOp_ex), 64'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
